// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage MIPS core: load-use bubble,
// multi-cycle mult/div occupancy of EX, and taken-branch IF/ID flush.
module hazard_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        ex_rt,
  input  logic              ex_memtoreg,
  input  logic              ex_muldiv,
  input  logic              id_branch_taken,
  output logic              pc_le,
  output logic              if_id_le,
  output logic              if_id_clear,
  output logic              id_ex_le,
  output logic              id_ex_clear,
  output logic              md_busy,
  output logic [STAT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t              state_q, state_d;
  logic [7:0]          md_cnt_q, md_cnt_d;
  logic [STAT_W-1:0]   stall_q, stall_d;
  logic                load_use;

  assign load_use = ex_memtoreg && (ex_rt != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rt)) ||
                     (id_uses_rt && (id_rt == ex_rt)));

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_d     = stall_q;
    pc_le       = 1'b1;
    if_id_le    = 1'b1;
    id_ex_le    = 1'b1;
    if_id_clear = 1'b0;
    id_ex_clear = 1'b0;
    md_busy     = 1'b0;

    if (reset) begin
      pc_le       = 1'b0;
      if_id_le    = 1'b0;
      id_ex_le    = 1'b0;
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
      state_d     = RUN;
      md_cnt_d    = '0;
      stall_d     = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_muldiv) begin
            pc_le    = 1'b0;
            if_id_le = 1'b0;
            id_ex_le = 1'b0;
            md_cnt_d = 8'(MD_LATENCY - 2);
            state_d  = MD_BUSY;
          end else if (load_use) begin
            // Bubble wins over a taken branch; the branch is re-resolved next cycle.
            pc_le       = 1'b0;
            if_id_le    = 1'b0;
            id_ex_clear = 1'b1;
          end else if (id_branch_taken) begin
            if_id_clear = 1'b1;
          end
        end
        MD_BUSY: begin
          md_busy = 1'b1;
          if (md_cnt_q != 8'd0) begin
            pc_le    = 1'b0;
            if_id_le = 1'b0;
            id_ex_le = 1'b0;
            md_cnt_d = md_cnt_q - 8'd1;
          end else begin
            // ex_muldiv is still high here; returning to RUN without a retrigger check.
            if_id_clear = id_branch_taken;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase

      if (!pc_le && (stall_q != '1))
        stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q  <= state_d;
    md_cnt_q <= md_cnt_d;
    stall_q  <= stall_d;
  end

  assign stall_cycles = stall_q;

endmodule
